// File: rtl/memory_stage.sv
// Memory stage: forwards ALU results, or runs one load/store on a request/grant/response
// data port, formatting store lanes and extending load data before writeback.
module memory_stage (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] rs2_data_i,
   output logic        stall_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        result_valid_o,
   output logic [31:0] result_o,
   output logic        fault_o
);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, wdata_q, result_q;
   logic [3:0]  be_q;
   logic [2:0]  funct3_q;
   logic        we_q, result_valid_q, fault_q;

   logic        mem_op, illegal, misaligned, start_mem;
   logic [1:0]  off;
   logic [3:0]  be_fmt;
   logic [31:0] wdata_fmt, shifted, load_val;

   assign off     = alu_result_i[1:0];
   assign mem_op  = mem_read_i | mem_write_i;
   // Loads accept B/H/W/BU/HU; stores only B/H/W.
   assign illegal = mem_read_i ? (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11)
                               : (funct3_i[2] || funct3_i[1:0] == 2'b11);
   assign misaligned = (funct3_i[1:0] == 2'b01 && off[0]) ||
                       (funct3_i[1:0] == 2'b10 && off != 2'b00);
   assign start_mem  = valid_i && mem_op && !illegal && !misaligned;

   always_comb begin
      be_fmt    = 4'b1111;
      wdata_fmt = rs2_data_i;
      unique case (funct3_i[1:0])
         2'b00: begin
            be_fmt    = 4'b0001 << off;
            wdata_fmt = {4{rs2_data_i[7:0]}};
         end
         2'b01: begin
            be_fmt    = off[1] ? 4'b1100 : 4'b0011;
            wdata_fmt = {2{rs2_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   assign shifted = dmem_rdata_i >> {addr_q[1:0], 3'b000};

   always_comb begin
      load_val = dmem_rdata_i;
      unique case (funct3_q)
         3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_val = {24'b0, shifted[7:0]};
         3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_val = {16'b0, shifted[15:0]};
         default: load_val = dmem_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_mem) state_d = StReq;
         StReq:   if (dmem_gnt_i) state_d = we_q ? StIdle : StWait;
         StWait:  if (dmem_rvalid_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      stall_o    = (state_q != StIdle);
      dmem_req_o = (state_q == StReq);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q         <= '0;
         wdata_q        <= '0;
         be_q           <= '0;
         funct3_q       <= '0;
         we_q           <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         fault_q        <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_mem) begin
                  addr_q   <= alu_result_i;
                  wdata_q  <= wdata_fmt;
                  be_q     <= be_fmt;
                  funct3_q <= funct3_i;
                  we_q     <= mem_write_i;
               end else if (valid_i) begin
                  result_q       <= alu_result_i;
                  result_valid_q <= 1'b1;
                  fault_q        <= mem_op;
               end
            end
            StReq: begin
               if (dmem_gnt_i && we_q) begin
                  result_q       <= '0;
                  result_valid_q <= 1'b1;
                  fault_q        <= 1'b0;
               end
            end
            StWait: begin
               if (dmem_rvalid_i) begin
                  result_q       <= load_val;
                  result_valid_q <= 1'b1;
                  fault_q        <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign dmem_we_o      = we_q;
   assign dmem_addr_o    = {addr_q[31:2], 2'b00};
   assign dmem_be_o      = be_q;
   assign dmem_wdata_o   = wdata_q;
   assign result_valid_o = result_valid_q;
   assign result_o       = result_q;
   assign fault_o        = fault_q;

endmodule
